// File: rtl/aes_trace_sequencer.sv
// aes_trace_sequencer: stimulus sequencer for AES power-analysis captures.
// Issues back-to-back encryptions separated by a programmable idle gap.
// Plaintext sources: fixed, increment, Galois LFSR, or fixed-vs-random (TVLA).
// Also drives a scope trigger and counts traces. A run can stop after NUM_TRACES.
// Optional feature: define SEQ_CHECKSUM_EN to add the 8-bit ciphertext checksum port.
module aes_trace_sequencer #(
  parameter int TEXT_W     = 128,
  parameter int GAP_W      = 8,
  parameter int CNT_W      = 16,
  parameter int NUM_TRACES = 0
) (
  input  logic              ICE_CLK,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [GAP_W-1:0]  gap,
  input  logic [TEXT_W-1:0] seed,
  input  logic [TEXT_W-1:0] fixed_text,
  input  logic              aes_busy,
  input  logic [TEXT_W-1:0] aes_text_out,
  output logic              aes_start,
  output logic [TEXT_W-1:0] aes_text_in,
  output logic              trigger,
  output logic [CNT_W-1:0]  trace_count,
`ifdef SEQ_CHECKSUM_EN
  output logic              done,
  output logic [7:0]        checksum
`else
  output logic              done
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_START,
    S_WAIT_BUSY,
    S_RUN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_FIXED,
    MODE_INC,
    MODE_LFSR,
    MODE_TVLA
  } mode_e;

  state_e            state, next_state;
  mode_e             mode_q;
  logic [TEXT_W-1:0] gen_q;
  logic [TEXT_W-1:0] gen_next;
  logic [TEXT_W-1:0] text_sel;
  logic [TEXT_W-1:0] seed_eff;
  logic [GAP_W-1:0]  gap_cnt;
  logic [1:0]        wait_cnt;
  logic              trace_done;
  logic              run_start;
  logic [CNT_W-1:0]  count_inc;

  // One step of the x^128+x^7+x^2+x+1 Galois LFSR (shift left, fold 0x87 into the low byte)
  function automatic logic [TEXT_W-1:0] lfsr_step(input logic [TEXT_W-1:0] s);
    logic [TEXT_W-1:0] r;
    r = {s[TEXT_W-2:0], 1'b0};
    if (s[TEXT_W-1]) begin
      r[7:0] = r[7:0] ^ 8'h87;
    end
    return r;
  endfunction

  assign run_start = (state == S_IDLE) && enable;
  assign count_inc = trace_count + CNT_W'(1);
  // An all-zero LFSR would lock up, so LFSR-based modes start from 1 instead
  assign seed_eff  = (mode[1] && (seed == '0)) ? TEXT_W'(1) : seed;

  // Plaintext for the next trace; TVLA alternates fixed (even n) and LFSR (odd n)
  always_comb begin
    text_sel = gen_q;
    case (mode_q)
      MODE_FIXED: text_sel = fixed_text;
      MODE_TVLA:  if (!trace_count[0]) text_sel = fixed_text;
      default:    text_sel = gen_q;
    endcase
  end

  // Generator advance applied on trace completion; TVLA steps only after odd traces
  always_comb begin
    gen_next = gen_q;
    case (mode_q)
      MODE_INC:  gen_next = gen_q + TEXT_W'(1);
      MODE_LFSR: gen_next = lfsr_step(gen_q);
      MODE_TVLA: if (trace_count[0]) gen_next = lfsr_step(gen_q);
      default:   gen_next = gen_q;
    endcase
  end

  // State register
  always_ff @(posedge ICE_CLK) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; WAIT_BUSY timeout and RUN exit share the trace-completion path
  always_comb begin
    next_state = state;
    trace_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) next_state = S_GAP;
      end
      S_GAP: begin
        if (!enable) begin
          next_state = S_IDLE;
        end else if (!aes_busy && (gap_cnt == '0)) begin
          next_state = S_START;
        end
      end
      S_START: begin
        next_state = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (aes_busy) begin
          next_state = S_RUN;
        end else if (wait_cnt == 2'd3) begin
          trace_done = 1'b1;
        end
      end
      S_RUN: begin
        if (!aes_busy) trace_done = 1'b1;
      end
      S_DONE: begin
        if (!enable) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (trace_done) begin
      if ((NUM_TRACES != 0) && (count_inc == CNT_W'(NUM_TRACES))) begin
        next_state = S_DONE;
      end else if (enable) begin
        next_state = S_GAP;
      end else begin
        next_state = S_IDLE;
      end
    end
  end

  // Datapath: outputs are registered from next_state so they line up with the state
  always_ff @(posedge ICE_CLK) begin
    if (reset) begin
      aes_start   <= 1'b0;
      aes_text_in <= '0;
      trigger     <= 1'b0;
      trace_count <= '0;
      done        <= 1'b0;
      gen_q       <= '0;
      mode_q      <= MODE_FIXED;
      gap_cnt     <= '0;
      wait_cnt    <= '0;
    end else begin
      aes_start <= (next_state == S_START);
      trigger   <= (next_state == S_START) || (next_state == S_WAIT_BUSY) ||
                   (next_state == S_RUN);
      done      <= (next_state == S_DONE);

      if (run_start) begin
        trace_count <= '0;
        gen_q       <= seed_eff;
        mode_q      <= mode_e'(mode);
      end else if (trace_done) begin
        trace_count <= count_inc;
        gen_q       <= gen_next;
      end

      if ((next_state == S_GAP) && (state != S_GAP)) begin
        gap_cnt <= gap;
      end else if ((state == S_GAP) && !aes_busy && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end

      if ((state == S_GAP) && (next_state == S_START)) begin
        aes_text_in <= text_sel;
      end

      wait_cnt <= (state == S_WAIT_BUSY) ? wait_cnt + 2'd1 : '0;
    end
  end

`ifdef SEQ_CHECKSUM_EN
  logic [7:0] text_fold;

  // XOR of all bytes of the captured ciphertext
  always_comb begin
    text_fold = '0;
    for (int unsigned i = 0; i < TEXT_W / 8; i++) begin
      text_fold = text_fold ^ aes_text_out[8*i +: 8];
    end
  end

  // Running checksum, cleared at run start, folded in on each trace completion
  always_ff @(posedge ICE_CLK) begin
    if (reset) begin
      checksum <= '0;
    end else if (run_start) begin
      checksum <= '0;
    end else if (trace_done) begin
      checksum <= checksum ^ text_fold;
    end
  end
`else
  // Ciphertext is not consumed without the checksum; this sink is trimmed in synthesis
  logic unused_text_out;
  assign unused_text_out = ^aes_text_out;
`endif

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// Directed bench for aes_trace_sequencer with a simple AES core busy model.
// Busy drops 10 cycles after the core samples aes_start.
// u_dut runs indefinitely; u_dut3 stops after 3 traces, sharing all inputs.
module tb_aes_trace_sequencer;
  localparam int TW = 128;
  localparam int CORE_LAT = 10;
  localparam logic [TW-1:0] FIXED = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
  localparam logic [TW-1:0] ONES = {TW{1'b1}};

  logic ICE_CLK = 1'b0;
  always #5 ICE_CLK = ~ICE_CLK;

  logic          reset, enable;
  logic [1:0]    mode;
  logic [7:0]    gap;
  logic [TW-1:0] seed, fixed_text;
  logic          aes_busy = 1'b0;
  logic [TW-1:0] aes_text_out = '0;
  logic          start0, trig0, done0, start3, trig3, done3;
  logic [TW-1:0] txt0, txt3;
  logic [15:0]   cnt0, cnt3;
`ifdef SEQ_CHECKSUM_EN
  logic [7:0]    csum0, csum3;
`endif

  aes_trace_sequencer #(.TEXT_W(128), .GAP_W(8), .CNT_W(16), .NUM_TRACES(0)) u_dut (
    .ICE_CLK(ICE_CLK), .reset(reset), .enable(enable), .mode(mode), .gap(gap),
    .seed(seed), .fixed_text(fixed_text), .aes_busy(aes_busy), .aes_text_out(aes_text_out),
    .aes_start(start0), .aes_text_in(txt0), .trigger(trig0), .trace_count(cnt0),
`ifdef SEQ_CHECKSUM_EN
    .checksum(csum0),
`endif
    .done(done0)
  );

  aes_trace_sequencer #(.TEXT_W(128), .GAP_W(8), .CNT_W(16), .NUM_TRACES(3)) u_dut3 (
    .ICE_CLK(ICE_CLK), .reset(reset), .enable(enable), .mode(mode), .gap(gap),
    .seed(seed), .fixed_text(fixed_text), .aes_busy(aes_busy), .aes_text_out(aes_text_out),
    .aes_start(start3), .aes_text_in(txt3), .trigger(trig3), .trace_count(cnt3),
`ifdef SEQ_CHECKSUM_EN
    .checksum(csum3),
`endif
    .done(done3)
  );

  // Core model, driven by u_dut: busy from the edge that samples start, for CORE_LAT-1 cycles
  logic [31:0]   core_n = '0;
  logic [31:0]   swb = '0;
  logic [3:0]    bcnt = '0;
  logic          core_mute;
  logic [TW-1:0] ct_tab [0:63];
  always @(posedge ICE_CLK) begin
    if (start0 && !core_mute) begin
      if (aes_busy) swb <= swb + 1;
      aes_busy     <= 1'b1;
      bcnt         <= 4'(CORE_LAT - 2);
      aes_text_out <= ct_tab[core_n[5:0]];
      core_n       <= core_n + 1;
    end else if (aes_busy) begin
      if (bcnt == 0) aes_busy <= 1'b0;
      else bcnt <= bcnt - 4'd1;
    end
  end

  // Cycle counter and start/trigger monitor
  logic [31:0]   cyc = '0;
  logic [31:0]   st_n = '0;
  logic [31:0]   st_cyc [0:255];
  logic [TW-1:0] st_txt [0:255];
  logic          trig_log [0:16383];
  always @(posedge ICE_CLK) cyc <= cyc + 1;
  always @(negedge ICE_CLK) begin
    trig_log[cyc[13:0]] <= trig0;
    if (start0) begin
      st_cyc[st_n[7:0]] <= cyc;
      st_txt[st_n[7:0]] <= txt0;
      st_n <= st_n + 1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_starts(input logic [31:0] target, input string name);
    int unsigned b = 0;
    while (st_n < target && b < 3000) begin
      @(negedge ICE_CLK);
      b++;
    end
    check(name, TW'(st_n >= target), TW'(1));
  endtask

  task automatic wait_idle(input string name);
    int unsigned b = 0;
    while ((trig0 || aes_busy) && b < 500) begin
      @(negedge ICE_CLK);
      b++;
    end
    check(name, TW'(!trig0 && !aes_busy), TW'(1));
    repeat (3) @(negedge ICE_CLK);
  endtask

  function automatic int count_trig(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    for (int unsigned c = a + 1; c <= b; c++) if (trig_log[14'(c)]) n++;
    return n;
  endfunction

  typedef struct packed {
    logic [1:0]          mode;
    logic [TW-1:0]       seed;
    logic [7:0]          gap;
    logic [2:0]          n;
    logic [5:0][TW-1:0]  exp;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] m, input logic [TW-1:0] s, input logic [7:0] g,
                              input logic [2:0] n, input logic [TW-1:0] e0, input logic [TW-1:0] e1,
                              input logic [TW-1:0] e2, input logic [TW-1:0] e3,
                              input logic [TW-1:0] e4, input logic [TW-1:0] e5);
    vec_t r;
    r.mode = m; r.seed = s; r.gap = g; r.n = n;
    r.exp[0] = e0; r.exp[1] = e1; r.exp[2] = e2;
    r.exp[3] = e3; r.exp[4] = e4; r.exp[5] = e5;
    return r;
  endfunction

  vec_t        vt [7];
  logic [31:0] base, c0, kc;
  logic [5:0]  ci;

  initial begin
    vt[0] = mk(2'd0, 128'h1234, 8'd3, 3'd3, FIXED, FIXED, FIXED, 0, 0, 0);
    vt[1] = mk(2'd3, 128'h1, 8'd0, 3'd6, FIXED, 128'h1, FIXED, 128'h2, FIXED, 128'h4);
    vt[2] = mk(2'd2, 128'h0, 8'd1, 3'd3, 128'h1, 128'h2, 128'h4, 0, 0, 0);
    vt[3] = mk(2'd1, ONES, 8'd2, 3'd2, ONES, 128'h0, 0, 0, 0, 0);
    vt[4] = mk(2'd2, {1'b1, 127'h0}, 8'd0, 3'd2, {1'b1, 127'h0}, 128'h87, 0, 0, 0, 0);
    vt[5] = mk(2'd3, 128'h0, 8'd4, 3'd4, FIXED, 128'h1, FIXED, 128'h2, 0, 0);
    vt[6] = mk(2'd1, 128'h0, 8'd0, 3'd3, 128'h0, 128'h1, 128'h2, 0, 0, 0);
    for (int i = 0; i < 64; i++) ct_tab[i] = '0;

    reset = 1'b1; enable = 1'b0; mode = 2'd0; gap = 8'd0; seed = '0;
    fixed_text = FIXED; core_mute = 1'b0;
    repeat (3) @(negedge ICE_CLK);
    check("rst_start", TW'(start0), 0);
    check("rst_text", txt0, 0);
    check("rst_trigger", TW'(trig0), 0);
    check("rst_count", TW'(cnt0), 0);
    check("rst_done", TW'(done0), 0);
`ifdef SEQ_CHECKSUM_EN
    check("rst_checksum", TW'(csum0), 0);
`endif
    reset = 1'b0;
    repeat (2) @(negedge ICE_CLK);

    // Table of runs: texts, first-start latency, spacing, trigger width, trace count
    for (int v = 0; v < 7; v++) begin
      base = st_n; mode = vt[v].mode; seed = vt[v].seed; gap = vt[v].gap;
      c0 = cyc; enable = 1'b1;
      wait_starts(base + 32'(vt[v].n), $sformatf("vec%0d_starts", v));
      enable = 1'b0;
      wait_idle($sformatf("vec%0d_idle", v));
      for (int i = 0; i < int'(vt[v].n); i++)
        check($sformatf("vec%0d_text%0d", v, i), st_txt[8'(base + 32'(i))], vt[v].exp[i]);
      check($sformatf("vec%0d_latency", v), TW'(st_cyc[8'(base)] - c0), TW'(vt[v].gap + 2));
      check($sformatf("vec%0d_spacing", v), TW'(st_cyc[8'(base + 1)] - st_cyc[8'(base)]),
            TW'(vt[v].gap + 12));
      check($sformatf("vec%0d_trig_len", v),
            TW'(count_trig(st_cyc[8'(base)], st_cyc[8'(base + 1)])), TW'(11));
      check($sformatf("vec%0d_count", v), TW'(cnt0), TW'(vt[v].n));
    end

    // Increment mode, gap 255, 3-trace run on u_dut3
    base = st_n; mode = 2'd1; seed = 128'h00112233445566778899aabbccddeeff; gap = 8'd255;
    c0 = cyc; enable = 1'b1;
    wait_starts(base + 3, "inc_starts");
    for (int b = 0; b < 40 && !done3; b++) @(negedge ICE_CLK);
    check("inc_done3", TW'(done3), 1);
    check("inc_count3", TW'(cnt3), 3);
    check("inc_done0", TW'(done0), 0);
    check("inc_count0", TW'(cnt0), 3);
    enable = 1'b0;
    wait_idle("inc_idle");
    check("inc_done3_cleared", TW'(done3), 0);
    check("inc_text0", st_txt[8'(base)], 128'h00112233445566778899aabbccddeeff);
    check("inc_text1", st_txt[8'(base + 1)], 128'h00112233445566778899aabbccddef00);
    check("inc_text2", st_txt[8'(base + 2)], 128'h00112233445566778899aabbccddef01);
    check("inc_latency", TW'(st_cyc[8'(base)] - c0), TW'(257));
    check("inc_spacing01", TW'(st_cyc[8'(base + 1)] - st_cyc[8'(base)]), TW'(267));
    check("inc_spacing12", TW'(st_cyc[8'(base + 2)] - st_cyc[8'(base + 1)]), TW'(267));

    // Enable dropped while RUN: current trace completes, then IDLE
    base = st_n; mode = 2'd1; seed = 128'h10; gap = 8'd2; enable = 1'b1;
    wait_starts(base + 1, "drop_starts");
    repeat (4) @(negedge ICE_CLK);
    enable = 1'b0;
    wait_idle("drop_idle");
    check("drop_count", TW'(cnt0), 1);
    check("drop_no_restart", TW'(st_n - base), 1);
    check("drop_text_held", txt0, 128'h10);
    check("drop_trigger", TW'(trig0), 0);

    // Reset pulsed during RUN of the second trace; restart waits for busy low
    base = st_n; mode = 2'd0; seed = '0; gap = 8'd3; enable = 1'b1;
    wait_starts(base + 2, "rst_run_starts");
    repeat (3) @(negedge ICE_CLK);
    reset = 1'b1;
    @(negedge ICE_CLK);
    check("rstrun_start", TW'(start0), 0);
    check("rstrun_trigger", TW'(trig0), 0);
    check("rstrun_count", TW'(cnt0), 0);
    check("rstrun_text", txt0, 0);
    check("rstrun_done", TW'(done0), 0);
    reset = 1'b0;
    for (int b = 0; b < 50 && aes_busy; b++) @(negedge ICE_CLK);
    kc = cyc;
    wait_starts(base + 3, "rstrun_restart");
    check("rstrun_restart_delay", TW'(st_cyc[8'(base + 2)] - kc), TW'(4));
    check("rstrun_restart_text", st_txt[8'(base + 2)], FIXED);
    enable = 1'b0;
    wait_idle("rstrun_idle");

    // Core never raises busy: WAIT_BUSY times out after 4 cycles and completes the trace
    core_mute = 1'b1;
    base = st_n; mode = 2'd1; seed = 128'h5; gap = 8'd0; enable = 1'b1;
    wait_starts(base + 2, "to_starts");
    enable = 1'b0;
    wait_idle("to_idle");
    core_mute = 1'b0;
    check("to_text0", st_txt[8'(base)], 128'h5);
    check("to_text1", st_txt[8'(base + 1)], 128'h6);
    check("to_spacing", TW'(st_cyc[8'(base + 1)] - st_cyc[8'(base)]), TW'(6));
    check("to_trig_len", TW'(count_trig(st_cyc[8'(base)], st_cyc[8'(base + 1)])), TW'(5));
    check("to_count", TW'(cnt0), 2);

`ifdef SEQ_CHECKSUM_EN
    ci = core_n[5:0];
    ct_tab[ci] = {8'h01, 120'h0};
    ct_tab[ci + 6'd1] = {8'h03, 120'h0};
    base = st_n; mode = 2'd0; gap = 8'd0; enable = 1'b1;
    wait_starts(base + 2, "cs_starts");
    check("cs_first", TW'(csum0), TW'(8'h01));
    enable = 1'b0;
    wait_idle("cs_idle");
    check("cs_second", TW'(csum0), TW'(8'h02));
`endif

    check("start_while_busy", TW'(swb), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_trace_sequencer.md
# aes_trace_sequencer

Parametrised stimulus sequencer for AES power-analysis captures on the iCE40 board. It sits between the board top-level and the AES core. It issues back-to-back encryptions separated by a programmable idle gap, and generates plaintexts in fixed, incrementing, pseudo-random or fixed-vs-random (TVLA) mode. It also drives a scope trigger, counts completed traces and stops after a configured number of traces.

## Interface
- `TEXT_W`, 128: plaintext/ciphertext width in bits.
- `GAP_W`, 8: width of the `gap` input.
- `CNT_W`, 16: width of `trace_count`.
- `NUM_TRACES`, 0: traces per run. 0 means run indefinitely.

Ports:
- `ICE_CLK` in 1: sole clock; every register is clocked on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: run request, level-sensitive.
- `mode` in 2: plaintext generator select. 0 = fixed, 1 = increment, 2 = LFSR, 3 = TVLA. Sampled on the IDLE→GAP transition only.
- `gap` in GAP_W: idle cycles between encryption completion and the next start. Sampled on each entry to GAP.
- `seed` in TEXT_W: initial plaintext / LFSR seed.
- `fixed_text` in TEXT_W: plaintext used in mode 0 and on even TVLA traces.
- `aes_busy` in 1: AES core busy flag.
- `aes_text_out` in TEXT_W: AES core ciphertext.
- `aes_start` out 1: one-cycle load pulse to the AES core.
- `aes_text_in` out TEXT_W: plaintext to the AES core. Registered; held stable between starts.
- `trigger` out 1: scope trigger, registered.
- `trace_count` out CNT_W: completed traces since run start.
- `done` out 1: run finished (NUM_TRACES reached).
- `checksum` out 8: XOR-fold of all captured ciphertexts. Present only with `SEQ_CHECKSUM_EN`.

## Operation
FSM states are IDLE, GAP, START, WAIT_BUSY, RUN and DONE.

State transitions:
- **IDLE → GAP:** when `enable`=1. On this transition:
  - `trace_count`←0 and `checksum`←0.
  - Generator state←`seed`. A zero seed is replaced by 1 in modes 2 and 3.
  - `mode` is latched.
  - Gap counter←`gap`.
- **GAP:** decrements the gap counter only while `aes_busy`=0. Goes to START when the counter is 0 and `aes_busy`=0, so `gap`=0 gives the minimum spacing.
- **START:** `aes_start`=1 for exactly this cycle, and `aes_text_in` already carries the new plaintext. Next state is WAIT_BUSY.
- **WAIT_BUSY:** waits for `aes_busy`=1, then goes to RUN. If busy does not rise within 4 cycles, the trace is treated as complete. This is the same path as the RUN exit.
- **RUN:** waits for `aes_busy`=0. On exit:
  - Capture the ciphertext into the checksum.
  - Increment `trace_count`; it wraps modulo 2^CNT_W when NUM_TRACES=0.
  - Advance the generator.
  - If NUM_TRACES≠0 and the new count equals NUM_TRACES, go to DONE. Otherwise, if `enable`=1, go to GAP with the counter reloaded. If `enable`=0, go to IDLE.
- **DONE:** `done`=1. Returns to IDLE when `enable`=0.
- Dropping `enable` in GAP returns to IDLE immediately. Dropping it during START/WAIT_BUSY/RUN lets the current encryption finish first; the core is never aborted.

Plaintext generation (`aes_text_in` for trace n, counting from 0):
- **Mode 0:** `fixed_text`.
- **Mode 1:** `seed` + n, modulo 2^TEXT_W.
- **Mode 2:** LFSR state. 128-bit Galois LFSR with polynomial x^128+x^7+x^2+x+1, shifted left one step per trace. When the shifted-out MSB is 1, XOR 0x87 into the low byte.
- **Mode 3:** even n uses `fixed_text`. Odd n uses the LFSR state, and the LFSR advances only after odd traces.

Other behaviour:
- `aes_text_in` is updated only in the cycle before START; its value is registered at GAP exit.
- `trigger` rises in the same cycle as `aes_start` and stays high through WAIT_BUSY and RUN. It falls in the cycle after RUN/WAIT_BUSY exit.

## Timing
- Reset values:
  - FSM = IDLE.
  - `aes_start`=0, `aes_text_in`=0, `trigger`=0, `trace_count`=0, `done`=0, `checksum`=0.
  - Generator state = 0.
- Reset in any state forces IDLE on the next edge and drops `aes_start`/`trigger` at once. A still-busy core is not reset by this block. The next GAP waits for `aes_busy`=0 before counting.
- `enable` rising with `aes_busy`=0 and `gap`=G gives the first `aes_start` at cycle G+2 after the rising edge.
- Busy falling (edge k) gives the next `aes_start` at edge k+G+2.
- `trace_count` and `checksum` update on the same edge as RUN exit.
- `done` asserts on that same edge and holds until IDLE.
- `reset` and `enable` asserted together: reset wins.

## Configuration
- **`SEQ_CHECKSUM_EN` defined:** the `checksum` port exists. On each trace completion, `checksum` ← `checksum` XOR the XOR of all sixteen bytes of `aes_text_out`. It is cleared on reset and on IDLE→GAP.
- **`SEQ_CHECKSUM_EN` undefined:** the port and its register are absent. No ciphertext bits are read, so the core output can be optimised away except where the top-level uses it.

## Test plan
- **Increment mode:** mode=1, seed=0x00112233445566778899aabbccddeeff, gap=255, NUM_TRACES=3, model core busy for 10 cycles. Required:
  - `aes_text_in` values …eeff, …ef00, …ef01.
  - Starts are exactly 267 cycles apart.
  - `done`=1 with `trace_count`=3.
- **Fixed and TVLA modes:** mode=0 gives a constant `fixed_text` at every start. mode=3, seed=1 gives fixed, 1, fixed, 2, fixed, 4.
- **LFSR mode and wrap:** mode=2, seed=0, first texts are 1, 2, 4. mode=1, seed=2^128−1, second text is 0.
- **Gap boundary:** gap=0, busy 10 cycles. Consecutive starts are 12 cycles apart, and `trigger` is high for 11 cycles per trace.
- **Enable drop and reset mid-run:**
  - `enable` dropped in RUN: the current trace completes, `trace_count` increments, and the FSM goes to IDLE.
  - `reset` pulsed in RUN: all outputs are 0 the next cycle, and the restart waits for `aes_busy`=0.
- **Checksum (`SEQ_CHECKSUM_EN`):** ciphertexts 0x01…00 then 0x03…00. Required `checksum` is 0x01 after the first trace, then 0x02.
